// File: rtl/raven_bus_pkg.sv
// Shared bus definitions for the 68000 glue logic: cycle states, decoded
// regions and the default wait/timeout constants used by decoder and system top.
package raven_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        IOWAIT,
        ACK,
        ERR
    } bus_state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_RAM,
        REG_ROM,
        REG_IO
    } region_t;

    localparam int DEF_RAM_WAIT       = 0;
    localparam int DEF_ROM_WAIT       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Simultaneous selects are legal; the DUART outranks ROM, which outranks RAM.
    function automatic region_t decode_region(input logic duart_cs_n,
                                              input logic rom_cs_n,
                                              input logic ram_cs_n);
        if (!duart_cs_n)    return REG_IO;
        else if (!rom_cs_n) return REG_ROM;
        else if (!ram_cs_n) return REG_RAM;
        else                return REG_NONE;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: saturating 8-bit clock counter that flags expiry once a
// cycle has been waiting TIMEOUT_CYCLES clocks.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (!reset)
            r_tcnt <= '0;
        else if (clear)
            r_tcnt <= '0;
        else if (enable && (r_tcnt != 8'hFF))
            r_tcnt <= r_tcnt + 8'd1;
    end

    assign expired = (r_tcnt == TCNT_LAST);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: per-region wait states, /DTACK generation and
// DUART ack hand-off. Define BUS_TIMEOUT_EN to add the /BERR watchdog.
module bus_cycle_ctrl
    import raven_bus_pkg::*;
#(
    parameter int RAM_WAIT       = DEF_RAM_WAIT,
    parameter int ROM_WAIT       = DEF_ROM_WAIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic as_n,
    input  logic ram_cs_n,
    input  logic rom_cs_n,
    input  logic duart_cs_n,
    input  logic duart_dtack_n,
    output logic dtack_n,
    output logic berr_n,
    output logic busy
);

    localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
    localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);

    bus_state_t r_state, w_state_nxt;
    region_t    r_region, w_region_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_dtack_n;
    logic       w_expired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_region  <= REG_NONE;
            r_cnt     <= '0;
            r_dtack_n <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_region  <= w_region_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dtack_n <= (w_state_nxt != ACK);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (!as_n) begin
                    w_region_nxt = decode_region(duart_cs_n, rom_cs_n, ram_cs_n);
                    case (w_region_nxt)
                        REG_IO:  w_state_nxt = IOWAIT;
                        REG_ROM: begin w_state_nxt = WAIT; w_cnt_nxt = ROM_CNT; end
                        REG_RAM: begin w_state_nxt = WAIT; w_cnt_nxt = RAM_CNT; end
`ifdef BUS_TIMEOUT_EN
                        // Unmapped: park with no ack source until the watchdog fires.
                        default: w_state_nxt = IOWAIT;
`else
                        default: begin w_state_nxt = WAIT; w_cnt_nxt = ROM_CNT; end
`endif
                    endcase
                end
            end
            WAIT: begin
                if (as_n)
                    w_state_nxt = IDLE;
                else if (r_cnt == 4'd0)
                    w_state_nxt = ACK;
                else if (w_expired)
                    w_state_nxt = ERR;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            IOWAIT: begin
                if (as_n)
                    w_state_nxt = IDLE;
                else if ((r_region == REG_IO) && !duart_dtack_n)
                    w_state_nxt = ACK;
                else if (w_expired)
                    w_state_nxt = ERR;
            end
            ACK, ERR: begin
                if (as_n)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic r_berr_n;

    always_ff @(posedge clk) begin
        if (!reset)
            r_berr_n <= 1'b1;
        else
            r_berr_n <= (w_state_nxt != ERR);
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == IDLE),
        .enable  ((r_state == WAIT) || (r_state == IOWAIT)),
        .expired (w_expired)
    );

    assign berr_n = r_berr_n;
`else
    assign w_expired = 1'b0;
    assign berr_n    = 1'b1;
`endif

    assign dtack_n = r_dtack_n;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios plus random bus
// cycles checked edge by edge against a transaction-level timing model.
module tb_bus_cycle_ctrl;

    localparam int RAM_W = 0;
    localparam int ROM_W = 3;
    localparam int TMO   = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic as_n = 1'b1;
    logic ram_cs_n = 1'b1;
    logic rom_cs_n = 1'b1;
    logic duart_cs_n = 1'b1;
    logic duart_dtack_n = 1'b1;
    logic dtack_n, berr_n, busy;

    int tests_run = 0;
    int tests_failed = 0;

    bus_cycle_ctrl #(
        .RAM_WAIT       (RAM_W),
        .ROM_WAIT       (ROM_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .as_n          (as_n),
        .ram_cs_n      (ram_cs_n),
        .rom_cs_n      (rom_cs_n),
        .duart_cs_n    (duart_cs_n),
        .duart_dtack_n (duart_dtack_n),
        .dtack_n       (dtack_n),
        .berr_n        (berr_n),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // One bus cycle: /AS sampled low on relative edges 0..len-1, high for gap edges.
    // The DUART acks from relative edge dly onwards. Outputs checked after every edge.
    task automatic do_cycle(input logic c_ram, input logic c_rom, input logic c_io,
                            input int len, input int dly, input int gap, input string tag);
        int  rel_ack;
        bit  ack_ok;
        bit  err_ok;
        logic exp_d, exp_b, exp_busy;
        if (!c_io)       rel_ack = (dly < 1) ? 1 : dly;
        else if (!c_rom) rel_ack = 1 + ROM_W;
        else if (!c_ram) rel_ack = 1 + RAM_W;
`ifdef BUS_TIMEOUT_EN
        else             rel_ack = 1000000;
`else
        else             rel_ack = 1 + ROM_W;
`endif
        ack_ok = (rel_ack <= len - 1);
`ifdef BUS_TIMEOUT_EN
        ack_ok = ack_ok && (rel_ack <= TMO);
        err_ok = !ack_ok && (TMO <= len - 1);
`else
        err_ok = 1'b0;
`endif
        ram_cs_n   = c_ram;
        rom_cs_n   = c_rom;
        duart_cs_n = c_io;
        for (int i = 0; i < len + gap; i++) begin
            as_n = (i < len) ? 1'b0 : 1'b1;
            if (!c_io) duart_dtack_n = !((i < len) && (i >= dly));
            else       duart_dtack_n = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            exp_d    = !(ack_ok && (i >= rel_ack) && (i < len));
            exp_b    = !(err_ok && (i >= TMO) && (i < len));
            exp_busy = (i < len);
            tests_run++;
            if (dtack_n !== exp_d) begin
                tests_failed++;
                $display("FAIL %s dtack_n edge+%0d: got %b expected %b", tag, i, dtack_n, exp_d);
            end
            tests_run++;
            if (berr_n !== exp_b) begin
                tests_failed++;
                $display("FAIL %s berr_n edge+%0d: got %b expected %b", tag, i, berr_n, exp_b);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy edge+%0d: got %b expected %b", tag, i, busy, exp_busy);
            end
        end
        duart_dtack_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        tests_run++;
        if ({dtack_n, berr_n, busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL %s dtack_n/berr_n/busy: got %b%b%b expected 110", tag, dtack_n, berr_n, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        as_n = 1'b0;
        ram_cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("reset_hold");
        end
        reset = 1'b1;
        as_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_ram();
        do_cycle(1'b0, 1'b1, 1'b1, 5, 0, 2, "ram");
    endtask

    task automatic test_rom();
        do_cycle(1'b1, 1'b0, 1'b1, ROM_W + 4, 0, 2, "rom");
        do_cycle(1'b0, 1'b0, 1'b1, ROM_W + 3, 0, 1, "rom_over_ram");
    endtask

    task automatic test_duart();
        do_cycle(1'b1, 1'b0, 1'b0, 7, 3, 2, "duart_over_rom");
        do_cycle(1'b0, 1'b1, 1'b0, 4, 0, 1, "duart_early_ack");
    endtask

    task automatic test_abort();
        do_cycle(1'b1, 1'b0, 1'b1, 2, 0, 1, "abort_rom");
        do_cycle(1'b1, 1'b1, 1'b0, 3, 9, 1, "abort_duart");
        do_cycle(1'b0, 1'b1, 1'b1, 4, 0, 2, "after_abort_ram");
    endtask

    task automatic test_unmapped();
        do_cycle(1'b1, 1'b1, 1'b1, TMO + 4, 0, 2, "unmapped");
        do_cycle(1'b1, 1'b1, 1'b0, TMO + 4, TMO + 2, 2, "duart_hang");
        do_cycle(1'b1, 1'b1, 1'b0, TMO + 3, TMO, 1, "duart_ack_at_timeout");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++)
            do_cycle(1'(k & 1), 1'(~k & 1), 1'b1, 6, 0, 1, "back_to_back");
    endtask

    task automatic test_reset_mid();
        as_n = 1'b0;
        ram_cs_n = 1'b0;
        rom_cs_n = 1'b1;
        duart_cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dtack_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid pre_ack dtack_n: got %b expected 0", dtack_n);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset_mid");
        reset = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b1, 4, 0, 2, "after_reset_fresh");
    endtask

    task automatic test_random();
        logic [2:0] sel;
        for (int k = 0; k < 40; k++) begin
            sel = 3'($urandom);
            do_cycle(sel[0], sel[1], sel[2], $urandom_range(1, 20),
                     $urandom_range(0, 18), $urandom_range(1, 3), "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time budget exceeded");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        test_reset();
        test_ram();
        test_rom();
        test_duart();
        test_abort();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
